// File: rtl/decl_stage_pkg.sv
// Shared definitions for the declaration-stage FIFO: width helpers and the
// occupancy classification derived from the entry count.
package decl_stage_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decl_stage_ram.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port, no reset on the storage.
module decl_stage_ram
  import decl_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ptr_w(DEPTH)-1:0]    waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [ptr_w(DEPTH)-1:0]    raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/decl_stage_fifo.sv
// Valid/ready FIFO between a producer and the declaration-check consumer.
// Occupancy state is implied by the count; overflow is a sticky error flag.
module decl_stage_fifo
  import decl_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef logic [WIDTH-1:0] word_t;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready_en;
  logic             r_overflow;
  occ_e             w_occ;
  logic             w_push;
  logic             w_pop;
  word_t            w_rdata;

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_count == FULL_CNT) begin
      w_occ = OCC_FULL;
    end
  end

  // r_ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = r_ready_en & (w_occ != OCC_FULL);
  assign out_valid = (w_occ != OCC_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? w_rdata : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (in_valid && (w_occ == OCC_FULL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  decl_stage_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

endmodule

// File: tb/tb_decl_stage_fifo.sv
// Self-checking bench for decl_stage_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_decl_stage_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  bit         m_en  = 0;
  bit         m_ovf = 0;

  decl_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_en  = 0;
    m_ovf = 0;
  endtask

  // Drive one cycle of stimulus, advance past the edge and update the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit push;
    bit pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    push = v && m_en && (q.size() < DEPTH);
    pop  = r && (q.size() > 0);
    if (v && q.size() == DEPTH) m_ovf = 1;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    m_en = 1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_pre got=%b exp=0", in_ready); end
    cycle(1'b1, 8'hEE, 1'b0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready_post got=%b exp=1", in_ready); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rel_no_push count got=%0d exp=0", count); end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_arst_count got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    m_en = 1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_in_ready got=%b exp=1", in_ready); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      n_tests++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      $display("[TB] push %h count=%0d", vals[i], count);
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL fill_head got=%h exp=11", out_data); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 8'h55, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", count); end
    cycle(1'b0, 8'h00, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_data !== vals[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, vals[i]); end
      $display("[TB] pop %h", out_data);
      cycle(1'b0, 8'h00, 1'b1);
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_stream();
    cycle(1'b1, 8'hA0, 1'b0);
    cycle(1'b1, 8'hA1, 1'b0);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL stream_prefill got=%0d exp=2", count); end
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (out_data !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 8'(8'hA0 + i)); end
      $display("[TB] stream pop %h push %h", out_data, 8'(8'hA2 + i));
      cycle(1'b1, 8'(8'hA2 + i), 1'b1);
      n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d exp=2", i, count); end
    end
    n_tests++; if (out_data !== 8'hAA) begin n_fail++; $display("FAIL stream_tail got=%h exp=aa", out_data); end
    cycle(1'b0, 8'h00, 1'b1);
    n_tests++; if (out_data !== 8'hAB) begin n_fail++; $display("FAIL stream_last got=%h exp=ab", out_data); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_fallthrough();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ft_empty got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_data = 8'h7E; out_ready = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ft_no_bypass got=%b exp=0", out_valid); end
    cycle(1'b1, 8'h7E, 1'b1);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h7E) begin n_fail++; $display("FAIL ft_visible got=%b/%h exp=1/7e", out_valid, out_data); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL ft_count got=%0d exp=1", count); end
    cycle(1'b0, 8'h00, 1'b1);
    n_tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL ft_popped got=%b/%0d exp=0/0", out_valid, count); end
    $display("[TB] test_fallthrough done");
  endtask

  task automatic test_random();
    logic [7:0] exp_data;
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic       r;
      logic [7:0] d;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      d = 8'($urandom);
      cycle(v, d, r);
      exp_data = (q.size() > 0) ? q[0] : 8'h00;
      n_tests++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      n_tests++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, out_valid, q.size() > 0); end
      n_tests++; if (in_ready !== (m_en && q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, q.size() < DEPTH); end
      n_tests++; if (out_data !== exp_data) begin n_fail++; $display("FAIL rnd_out_data[%0d] got=%h exp=%h", i, out_data, exp_data); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d] got=%b exp=%b", i, overflow, m_ovf); end
      if (i % 50 == 0) $display("[TB] random cycle %0d count=%0d", i, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_stream();
    test_fallthrough();
    // Fresh reset so the random phase also exercises overflow from a clean flag.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
